// File: rtl/tnoc_axi_read_outstanding_limiter.sv
// rtl/tnoc_axi_read_outstanding_limiter.sv - AXI read outstanding-burst limiter with R beat buffer
module tnoc_axi_read_outstanding_limiter #(
    parameter int ID_WIDTH        = 8,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 256,
    parameter int MAX_OUTSTANDING = 4,
    parameter int R_FIFO_DEPTH    = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   s_arvalid,
    output logic                                   s_arready,
    input  logic [ID_WIDTH-1:0]                    s_arid,
    input  logic [ADDR_WIDTH-1:0]                  s_araddr,
    input  logic [7:0]                             s_arlen,
    input  logic [2:0]                             s_arsize,
    input  logic [1:0]                             s_arburst,
    output logic                                   m_arvalid,
    input  logic                                   m_arready,
    output logic [ID_WIDTH-1:0]                    m_arid,
    output logic [ADDR_WIDTH-1:0]                  m_araddr,
    output logic [7:0]                             m_arlen,
    output logic [2:0]                             m_arsize,
    output logic [1:0]                             m_arburst,
    input  logic                                   m_rvalid,
    output logic                                   m_rready,
    input  logic [ID_WIDTH-1:0]                    m_rid,
    input  logic [DATA_WIDTH-1:0]                  m_rdata,
    input  logic [1:0]                             m_rresp,
    input  logic                                   m_rlast,
    output logic                                   s_rvalid,
    input  logic                                   s_rready,
    output logic [ID_WIDTH-1:0]                    s_rid,
    output logic [DATA_WIDTH-1:0]                  s_rdata,
    output logic [1:0]                             s_rresp,
    output logic                                   s_rlast,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding,
    output logic                                   o_busy
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = $clog2(R_FIFO_DEPTH);
    localparam int EW = ID_WIDTH + DATA_WIDTH + 3;

    logic [CW-1:0] count;
    logic          limit;
    logic          inc;
    logic          dec;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] mem [R_FIFO_DEPTH];
    logic [EW-1:0] head;

    // AR gating: the limit only rises on an AR handshake, so a raised m_arvalid is never withdrawn
    assign limit     = (count == CW'(MAX_OUTSTANDING));
    assign m_arvalid = s_arvalid & ~limit;
    assign s_arready = m_arready & ~limit;
    assign m_arid    = s_arid;
    assign m_araddr  = s_araddr;
    assign m_arlen   = s_arlen;
    assign m_arsize  = s_arsize;
    assign m_arburst = s_arburst;

    // Credits return when RLAST leaves upstream, so beats still buffered keep their credit
    assign inc = m_arvalid & m_arready;
    assign dec = s_rvalid & s_rready & s_rlast;

    // Outstanding burst counter, saturating at zero on a stray RLAST
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CW'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign full     = (occ == (PW+1)'(R_FIFO_DEPTH));
    assign empty    = (occ == '0);
    assign m_rready = ~full;
    assign s_rvalid = ~empty;
    assign push     = m_rvalid & m_rready;
    assign pop      = s_rvalid & s_rready;

    // Beat storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {m_rid, m_rdata, m_rresp, m_rlast};
        end
    end

    // FIFO pointers and occupancy; reset discards every buffered beat
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                occ <= occ + (PW+1)'(1);
            end else if (pop && !push) begin
                occ <= occ - (PW+1)'(1);
            end
        end
    end

    assign head = mem[rd_ptr];
    assign {s_rid, s_rdata, s_rresp, s_rlast} = head;

    assign o_outstanding = count;
    assign o_busy        = (count != '0) | ~empty;

    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst) !(dec && !inc && (count == '0)));
    a_no_overissue: assert property (@(posedge i_clk) disable iff (i_rst) !(inc && limit));

endmodule

// File: tb/tb_tnoc_axi_read_outstanding_limiter.sv
// tb/tb_tnoc_axi_read_outstanding_limiter.sv - directed scoreboard bench for the read outstanding limiter
module tb_tnoc_axi_read_outstanding_limiter;

    logic         i_clk;
    logic         i_rst;
    logic         s_arvalid;
    logic         s_arready;
    logic [7:0]   s_arid;
    logic [63:0]  s_araddr;
    logic [7:0]   s_arlen;
    logic [2:0]   s_arsize;
    logic [1:0]   s_arburst;
    logic         m_arvalid;
    logic         m_arready;
    logic [7:0]   m_arid;
    logic [63:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic         m_rvalid;
    logic         m_rready;
    logic [7:0]   m_rid;
    logic [255:0] m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic         s_rvalid;
    logic         s_rready;
    logic [7:0]   s_rid;
    logic [255:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic [2:0]   o_outstanding;
    logic         o_busy;

    tnoc_axi_read_outstanding_limiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .o_outstanding(o_outstanding), .o_busy(o_busy)
    );

    typedef struct {
        logic [7:0]   id;
        logic [255:0] data;
        logic         last;
    } beat_t;

    beat_t      rq[$];
    beat_t      sb[$];
    logic [7:0] arq[$];
    int nerr = 0;
    int nchk = 0;
    int ar_hs = 0;
    int racc = 0;
    int nlast = 0;
    int npop = 0;
    logic [7:0] last_arid = '0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s_arvalid = (arq.size() != 0);
        if (arq.size() != 0) begin
            s_arid    = arq[0];
            s_araddr  = 64'h1000 + 64'(arq[0]);
            s_arlen   = arq[0];
            s_arsize  = 3'd5;
            s_arburst = 2'b01;
        end
        m_rvalid = (rq.size() != 0);
        if (rq.size() != 0) begin
            m_rid   = rq[0].id;
            m_rdata = rq[0].data;
            m_rlast = rq[0].last;
        end
        m_rresp = 2'b00;
    endtask

    // Called at a falling edge: sample handshakes, advance one clock, re-drive, return at the next falling edge
    task automatic cycle();
        beat_t b;
        logic [7:0] id;
        #1;
        if (s_arvalid && s_arready) begin
            id = arq.pop_front();
            chk("ar_fwd_valid", 256'(m_arvalid), 256'(1'b1));
            chk("ar_fwd_id", 256'(m_arid), 256'(id));
            chk("ar_fwd_addr", 256'(m_araddr), 256'(64'h1000 + 64'(id)));
            chk("ar_fwd_len", 256'(m_arlen), 256'(id));
            ar_hs++;
            last_arid = id;
        end
        if (m_rvalid && m_rready) begin
            sb.push_back(rq.pop_front());
            racc++;
        end
        if (s_rvalid && s_rready) begin
            npop++;
            if (sb.size() == 0) begin
                chk("r_unexpected_beat", 256'(s_rvalid), 256'(1'b0));
            end else begin
                b = sb.pop_front();
                chk("r_id", 256'(s_rid), 256'(b.id));
                chk("r_data", s_rdata, b.data);
                chk("r_last", 256'(s_rlast), 256'(b.last));
                if (b.last) nlast++;
            end
        end
        @(posedge i_clk);
        #1;
        drive();
        @(negedge i_clk);
    endtask

    initial begin
        beat_t b;
        int hs0;
        int nl0;
        i_rst = 1'b1;
        s_rready = 1'b0;
        m_arready = 1'b1;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        m_rid = '0; m_rdata = '0; m_rlast = 1'b0;
        drive();
        @(negedge i_clk);
        cycle();
        cycle();
        i_rst = 1'b0;
        cycle();
        chk("reset_s_rvalid", 256'(s_rvalid), 256'(1'b0));
        chk("reset_m_rready", 256'(m_rready), 256'(1'b1));
        chk("reset_outstanding", 256'(o_outstanding), 256'(3'd0));
        chk("reset_busy", 256'(o_busy), 256'(1'b0));

        // Credit limit: five ARs, only four may issue
        for (int i = 0; i < 5; i++) arq.push_back(8'(i));
        drive();
        for (int i = 0; i < 6; i++) cycle();
        chk("limit_hs_count", 256'(ar_hs), 256'(4));
        chk("limit_outstanding", 256'(o_outstanding), 256'(3'd4));
        chk("limit_s_arready", 256'(s_arready), 256'(1'b0));
        chk("limit_m_arvalid", 256'(m_arvalid), 256'(1'b0));
        chk("limit_busy", 256'(o_busy), 256'(1'b1));

        b.id = 8'd0; b.data = 256'hA0; b.last = 1'b1;
        rq.push_back(b);
        s_rready = 1'b1;
        drive();
        cycle();
        chk("limit_hold_while_buffered", 256'(o_outstanding), 256'(3'd4));
        cycle();
        chk("credit_return", 256'(o_outstanding), 256'(3'd3));
        chk("credit_m_arvalid", 256'(m_arvalid), 256'(1'b1));
        cycle();
        chk("id4_issued", 256'(last_arid), 256'(8'd4));
        chk("limit_back_to_4", 256'(o_outstanding), 256'(3'd4));

        // Drain to two outstanding, then overlap an AR with an RLAST pop
        for (int i = 1; i <= 2; i++) begin
            b.id = 8'(i); b.data = 256'(8'hB0 + i); b.last = 1'b1;
            rq.push_back(b);
        end
        drive();
        for (int i = 0; i < 3; i++) cycle();
        chk("drain_to_2", 256'(o_outstanding), 256'(3'd2));
        b.id = 8'd3; b.data = 256'hC3; b.last = 1'b1;
        rq.push_back(b);
        drive();
        cycle();
        hs0 = ar_hs;
        arq.push_back(8'd5);
        drive();
        cycle();
        chk("incdec_hs", 256'(ar_hs), 256'(hs0 + 1));
        chk("incdec_count", 256'(o_outstanding), 256'(3'd2));

        // FIFO full back-pressure with ten offered beats
        s_rready = 1'b0;
        racc = 0;
        for (int i = 0; i < 10; i++) begin
            b.id = 8'd7; b.data = 256'(i); b.last = (i == 9);
            rq.push_back(b);
        end
        drive();
        for (int i = 0; i < 12; i++) cycle();
        chk("full_accepted", 256'(racc), 256'(8));
        chk("full_m_rready", 256'(m_rready), 256'(1'b0));
        chk("full_s_rvalid", 256'(s_rvalid), 256'(1'b1));
        chk("full_head_data", s_rdata, 256'(0));
        nl0 = nlast;
        s_rready = 1'b1;
        for (int i = 0; i < 14; i++) cycle();
        chk("full_all_accepted", 256'(racc), 256'(10));
        chk("full_one_rlast", 256'(nlast), 256'(nl0 + 1));
        chk("full_count_dec", 256'(o_outstanding), 256'(3'd1));
        chk("full_sb_empty", 256'(sb.size()), 256'(0));

        // Throughput: one beat per cycle with single-cycle latency
        for (int i = 0; i < 16; i++) begin
            b.id = 8'(i); b.data = 256'(16'h100 + i); b.last = (i == 15);
            rq.push_back(b);
        end
        drive();
        cycle();
        chk("tp_latency_valid", 256'(s_rvalid), 256'(1'b1));
        chk("tp_latency_data", s_rdata, 256'(16'h100));
        for (int i = 1; i < 16; i++) begin
            cycle();
            chk("tp_stream_valid", 256'(s_rvalid), 256'(1'b1));
            chk("tp_stream_data", s_rdata, 256'(16'h100 + i));
        end
        cycle();
        chk("tp_done_busy", 256'(o_busy), 256'(1'b0));
        chk("tp_done_count", 256'(o_outstanding), 256'(3'd0));

        // Reset mid-operation discards credits and buffered beats
        s_rready = 1'b0;
        arq.push_back(8'd8);
        arq.push_back(8'd9);
        for (int i = 0; i < 3; i++) begin
            b.id = 8'd9; b.data = 256'(20'hDEAD0 + i); b.last = 1'b0;
            rq.push_back(b);
        end
        drive();
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_reset_count", 256'(o_outstanding), 256'(3'd2));
        chk("pre_reset_accepted", 256'(sb.size()), 256'(3));
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        sb.delete();
        chk("post_reset_s_rvalid", 256'(s_rvalid), 256'(1'b0));
        chk("post_reset_count", 256'(o_outstanding), 256'(3'd0));
        chk("post_reset_busy", 256'(o_busy), 256'(1'b0));
        chk("post_reset_m_rready", 256'(m_rready), 256'(1'b1));
        npop = 0;
        s_rready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("no_stale_beats", 256'(npop), 256'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/tnoc_axi_read_outstanding_limiter.md
Name: tnoc_axi_read_outstanding_limiter

Overview:
- Sits on the AXI read channels between the AXI master read adapter (upstream, `s_` side) and the AXI slave or interconnect (downstream, `m_` side).
- Caps the number of outstanding read bursts at MAX_OUTSTANDING.
- Buffers R beats in a FIFO so that slave-side R traffic is decoupled from NoC back-pressure on the adapter.
- AR is passed through combinationally but gated by the outstanding count.

Parameters:
- ID_WIDTH, 8, AXI ARID/RID width.
- ADDR_WIDTH, 64, ARADDR width.
- DATA_WIDTH, 256, RDATA width.
- MAX_OUTSTANDING, 4, max AR bursts issued without a returned RLAST beat; legal range 1..64.
- R_FIFO_DEPTH, 8, R beat buffer entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- s_arvalid/s_arready  in/out  1/1  upstream AR handshake
- s_arid, s_araddr, s_arlen, s_arsize, s_arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  upstream AR payload
- m_arvalid/m_arready  out/in  1/1  downstream AR handshake
- m_arid, m_araddr, m_arlen, m_arsize, m_arburst  out  same widths as s_ar*  downstream AR payload, wired straight from s_ar*
- m_rvalid/m_rready  in/out  1/1  downstream R handshake
- m_rid, m_rdata, m_rresp, m_rlast  in  ID_WIDTH/DATA_WIDTH/2/1  downstream R payload
- s_rvalid/s_rready  out/in  1/1  upstream R handshake
- s_rid, s_rdata, s_rresp, s_rlast  out  ID_WIDTH/DATA_WIDTH/2/1  upstream R payload from FIFO head
- o_outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding burst count
- o_busy  out  1  high when o_outstanding is non-zero or the FIFO is non-empty

Behaviour:
- Reset (i_rst high at a clock edge):
  - count = 0; FIFO read pointer, write pointer and occupancy = 0.
  - s_rvalid = 0, o_busy = 0, o_outstanding = 0.
  - m_rready = 1 in the first cycle after reset.
  - Reset mid-burst discards all buffered beats and all credits; no beat is presented after reset.
- AR path, all combinational:
  - limit = (count == MAX_OUTSTANDING).
  - m_arvalid = s_arvalid & ~limit; s_arready = m_arready & ~limit.
  - m_ar* payload is passed through unmodified.
  - AR must not be dropped: once m_arvalid is high, limit cannot rise before the handshake, because count only rises on an AR handshake.
- Outstanding counter:
  - inc = m_arvalid & m_arready; dec = s_rvalid & s_rready & s_rlast.
  - inc only: count+1. dec only: count-1. Both in the same cycle: count unchanged.
  - Count decrements on RLAST leaving upstream, not on RLAST arriving from downstream, so buffered beats still hold a credit.
  - dec with count==0 is a protocol error: count saturates at 0; simulation assertion fires.
  - inc while count==MAX_OUTSTANDING is unreachable; assertion.
- R FIFO:
  - Entry = {rid, rdata, rresp, rlast}.
  - push = m_rvalid & m_rready, with m_rready = ~full; no write-through when full.
  - pop = s_rvalid & s_rready, with s_rvalid = ~empty; s_r* driven from the head entry.
  - Latency: a beat accepted at edge N is visible on s_r* in the cycle after edge N (one cycle minimum, no combinational bypass).
  - Simultaneous push and pop: occupancy unchanged; legal at any occupancy except full, where push is blocked.
  - Pointers wrap modulo R_FIFO_DEPTH. Full = occupancy==R_FIFO_DEPTH; empty = occupancy==0.
  - s_r* payload and s_rvalid stay stable while s_rvalid & ~s_rready (AXI rule).
- Ordering: beats leave in arrival order. No reordering or de-interleaving; interleaved RIDs pass through unchanged.
- o_busy = (count != 0) | ~empty, combinational.

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles, then 0 -> s_rvalid=0, m_rready=1, o_outstanding=0, o_busy=0.
- Credit limit: MAX_OUTSTANDING=4, m_arready=1, 5 back-to-back ARs with IDs 0..4 -> 4 handshakes, o_outstanding=4, s_arready=0 and m_arvalid=0 for ID 4. One RLAST popped upstream -> ID 4 issues the next cycle; count returns to 4.
- Simultaneous inc/dec: with count=2, an AR handshake and an upstream RLAST pop in the same cycle -> count stays 2.
- FIFO full back-pressure: R_FIFO_DEPTH=8, s_rready=0, 10 beats (arlen=9) offered -> exactly 8 accepted, then m_rready=0. s_rready=1 -> beats emerge in order with data 0..9, rlast only on beat 9; count decrements once.
- Throughput: s_rready=1 and m_rvalid=1 continuous for 16 beats -> one beat per cycle on s_r*, 1-cycle latency, occupancy stays at 1.
- Reset mid-operation: 3 beats buffered, count=2, assert i_rst -> s_rvalid=0, o_outstanding=0 next cycle; the stale beats never appear afterwards.
